code_packer: RTL
================

Name: code_packer

Overview:
- Downstream stage of the character compressor: takes variable-length compressed codes (1–8 bits each) and packs them MSB-first into a continuous stream of 8-bit bytes.
- Feeds the byte-oriented transmit path.
- Valid/ready handshake on both sides.
- A flush request pads the final partial byte and signals completion.

Parameters:
- LEN_W, 4, width of the code-length input (values 0–8 legal).
- PAD_BIT, 0, bit value used to pad the final partial byte on flush.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CODE_IN  input  8  compressed code; valid bits are CODE_IN[LEN_IN-1:0], emitted MSB first.
- LEN_IN  input  LEN_W  number of valid code bits.
- IN_VALID  input  1  code present.
- IN_READY  output  1  packer can accept a code this cycle.
- FLUSH  input  1  single-cycle request to pad and drain the residual bits.
- OUT  output  8  packed byte.
- OUT_VALID  output  1  OUT holds a complete byte.
- OUT_READY  input  1  consumer takes the byte.
- FLUSH_DONE  output  1  one-cycle pulse when the flush has completed.

Behaviour:
- State: ACC[15:0] bit accumulator, left-justified (oldest bit at ACC[15]); FILL[4:0] bit count, 0–16; FSM state {RUN, DRAIN, DONE}.
- Reset (async, RST_N=0): ACC=0, FILL=0, state=RUN, OUT=0, OUT_VALID=0, FLUSH_DONE=0. IN_READY=1 as soon as RST_N is released.
- IN_READY = (state==RUN) && (FILL<=8).
- Input acceptance (IN_VALID && IN_READY):
  - Code bits are appended at ACC[15-FILL] downward.
  - FILL += LEN_IN.
  - LEN_IN=0 is accepted with no change to ACC or FILL.
  - LEN_IN>8 is clamped to 8.
- Output:
  - OUT_VALID = (FILL>=8) || (state==DRAIN && FILL>0).
  - OUT = ACC[15:8], driven from registers (no combinational path from inputs).
  - On OUT_VALID && OUT_READY: ACC shifts left by 8, zero-fill; FILL -= 8, floored at 0 in DRAIN.
- Same-cycle output pop and input push:
  - The pop applies first, then the new code is appended at the post-pop FILL position.
  - No bit is lost or duplicated.
  - Zero-bubble throughput: one byte per cycle when codes are 8 bits.
- Latency: a byte completed by the push at edge N has OUT_VALID=1 after edge N.
- FSM transitions:
  - RUN → DRAIN on FLUSH=1. A code presented with FLUSH in the same cycle is accepted first and is included in the drain.
  - On DRAIN entry, bits below ACC[15-FILL] are forced to PAD_BIT.
  - In DRAIN, IN_READY=0. All bytes are emitted, including the final partial byte padded to 8 bits.
  - DRAIN → DONE when FILL reaches 0. DRAIN is still entered when FILL is already 0 at the flush, in which case it exits on the next edge.
  - DONE: FLUSH_DONE=1 for exactly one cycle, then → RUN with ACC=0, FILL=0.
- FLUSH while in DRAIN or DONE is ignored.
- OUT_READY low holds OUT and OUT_VALID stable until the handshake.
- Reset asserted mid-DRAIN aborts the flush immediately. No FLUSH_DONE pulse follows.

Optional Feature:
- Macro CODE_PACKER_BYTECNT_EN.
- Defined:
  - Adds output BYTE_CNT[15:0], reset 0.
  - Increments on every OUT handshake, wraps 0xFFFF→0.
  - Cleared in the DONE cycle, after the last increment is visible for one cycle.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pack: push (CODE 3'b101, LEN 3) then (5'b11001, LEN 5), OUT_READY=1 → one byte OUT=0xB9, OUT_VALID for one cycle, FILL=0 afterwards.
- Flush pad: push (3'b110, LEN 3), then FLUSH pulse → IN_READY=0, OUT=0xC0 with PAD_BIT=0 (0xDF with PAD_BIT=1), FLUSH_DONE pulses one cycle after the handshake, IN_READY returns to 1.
- Backpressure:
  - With OUT_READY=0, push 0xA5 and 0x3C (LEN 8 each) → both accepted, FILL=16, IN_READY=0, OUT=0xA5 held.
  - Raise OUT_READY → 0xA5 then 0x3C on consecutive cycles; IN_READY=1 after the first pop.
- Streaming: 4 back-to-back 8-bit codes 0x35, 0x05, 0x44, 0xB3 with OUT_READY=1 → the same bytes out, one per cycle, no bubbles, 1-cycle latency. Then push LEN_IN=0 → no output, FILL unchanged.
- Simultaneous: FILL=12 and OUT_READY=1, push a 4-bit code in the same cycle → the byte pops and the new bits append at post-pop FILL position 4, giving FILL=8 next cycle with the correct byte order.
- Reset mid-drain: push 5 bits, FLUSH, assert RST_N=0 in the DRAIN cycle → outputs are immediately at reset values, no FLUSH_DONE. With CODE_PACKER_BYTECNT_EN defined, BYTE_CNT=0.

Source files
------------

// File: rtl/code_packer.sv
// -----------------------------------------------------------------------------
// code_packer
//   Packs variable-length codes (0..8 bits, MSB first) into a continuous
//   stream of 8-bit bytes. Valid/ready on both sides. A FLUSH request pads the
//   residual partial byte with PAD_BIT, drains every remaining byte and then
//   pulses FLUSH_DONE for one cycle.
//
//   Optional feature: define CODE_PACKER_BYTECNT_EN to add a 16-bit BYTE_CNT
//   output counting output handshakes (cleared when a flush completes).
//
//   Accumulator: r_acc[15:0] is left-justified, so the oldest bit sits at
//   r_acc[15]. r_fill (0..16) is the number of valid bits. Bits below the
//   fill point are always zero while running.
// -----------------------------------------------------------------------------
module code_packer #(
  parameter int   LEN_W   = 4,
  parameter logic PAD_BIT = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       CODE_IN,
  input  logic [LEN_W-1:0] LEN_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FLUSH,
  output logic [7:0]       OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             FLUSH_DONE
`ifdef CODE_PACKER_BYTECNT_EN
  ,
  output logic [15:0]      BYTE_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // State and registered outputs
  state_t      r_state;
  logic [15:0] r_acc;
  logic [4:0]  r_fill;
  logic [7:0]  r_out;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        r_flush_done;

  // Datapath wires
  logic        w_pop;
  logic        w_push;
  logic [3:0]  w_len;
  logic [7:0]  w_code_mask;
  logic [7:0]  w_code;
  logic [15:0] w_acc_pop;
  logic [4:0]  w_fill_pop;
  logic [4:0]  w_shamt;
  logic [15:0] w_ins;
  logic [15:0] w_acc_push;
  logic [4:0]  w_fill_push;
  logic [15:0] w_pad_mask;
  logic [15:0] w_acc_pad;

  // Next-state wires
  state_t      w_state_nxt;
  logic [15:0] w_acc_nxt;
  logic [4:0]  w_fill_nxt;

  assign OUT        = r_out;
  assign OUT_VALID  = r_out_valid;
  assign IN_READY   = r_in_ready;
  assign FLUSH_DONE = r_flush_done;

  // Handshakes use only registered flags, so neither side sees a
  // combinational path through the packer.
  assign w_pop  = r_out_valid & OUT_READY;
  assign w_push = IN_VALID & r_in_ready;

  // Clamp over-long lengths to a full byte and drop bits above the length.
  assign w_len       = (LEN_IN > LEN_W'(8)) ? 4'd8 : 4'(LEN_IN);
  assign w_code_mask = 8'((9'h001 << w_len) - 9'h001);
  assign w_code      = CODE_IN & w_code_mask;

  // Pop is applied first: the head byte leaves and the rest moves up.
  // While running a pop only happens with at least 8 bits held; in drain the
  // last partial byte floors the count at zero.
  assign w_acc_pop  = w_pop ? {r_acc[7:0], 8'h00} : r_acc;
  assign w_fill_pop = w_pop ? ((r_fill >= 5'd8) ? (r_fill - 5'd8) : 5'd0) : r_fill;

  // New code lands just below the post-pop fill point. A push is only
  // accepted with fill <= 8, so fill + len never exceeds 16 and the shift
  // amount stays in 0..16 (16 shifts the code out entirely, i.e. LEN=0).
  assign w_shamt     = 5'd16 - w_fill_pop - {1'b0, w_len};
  assign w_ins       = w_push ? ({8'h00, w_code} << w_shamt) : 16'h0000;
  assign w_acc_push  = w_acc_pop | w_ins;
  assign w_fill_push = w_fill_pop + (w_push ? {1'b0, w_len} : 5'd0);

  // Everything below the final fill point becomes PAD_BIT when draining starts.
  assign w_pad_mask = 16'hFFFF >> w_fill_push;
  assign w_acc_pad  = (w_acc_push & ~w_pad_mask) | ({16{PAD_BIT}} & w_pad_mask);

  // Next-state decode for the RUN / DRAIN / DONE sequencer
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    case (r_state)
      ST_RUN: begin
        // A code offered together with FLUSH is absorbed before padding.
        w_acc_nxt  = w_acc_push;
        w_fill_nxt = w_fill_push;
        if (FLUSH) begin
          w_acc_nxt   = w_acc_pad;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Inputs are blocked and further FLUSH requests are ignored.
        w_acc_nxt  = w_acc_pop;
        w_fill_nxt = w_fill_pop;
        if (w_fill_pop == 5'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_acc_nxt   = 16'h0000;
        w_fill_nxt  = 5'd0;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_acc_nxt   = 16'h0000;
        w_fill_nxt  = 5'd0;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State registers plus outputs registered from the next-state values
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_RUN;
      r_acc        <= 16'h0000;
      r_fill       <= 5'd0;
      r_out        <= 8'h00;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_flush_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_fill       <= w_fill_nxt;
      r_out        <= w_acc_nxt[15:8];
      r_out_valid  <= (w_fill_nxt >= 5'd8) ||
                      ((w_state_nxt == ST_DRAIN) && (w_fill_nxt != 5'd0));
      r_in_ready   <= (w_state_nxt == ST_RUN) && (w_fill_nxt <= 5'd8);
      r_flush_done <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef CODE_PACKER_BYTECNT_EN
  logic [15:0] r_byte_cnt;

  assign BYTE_CNT = r_byte_cnt;

  // Output handshake counter; it wraps naturally and clears when a flush
  // completes, leaving the final count visible during the DONE cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_byte_cnt <= 16'h0000;
    end else if (r_state == ST_DONE) begin
      r_byte_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_byte_cnt <= r_byte_cnt + 16'h0001;
    end
  end
`endif

endmodule
